// File: rtl/call_panel_pkg.sv
// Shared definitions for the call panel: floor state encoding and floor count.
package call_panel_pkg;

  localparam int NUM_FLOORS = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    SERVE   = 2'b10
  } floor_state_t;

endpackage

// File: rtl/call_debounce.sv
// Call button debouncer: emits a one-cycle press after DEBOUNCE_CYCLES
// consecutive high samples, once per continuous hold.
module call_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_FIRE = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Saturating at DEBOUNCE_CYCLES keeps the fire compare from matching again
  // until the button has been released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!btn) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign press = btn & (cnt == CNT_FIRE);

endmodule

// File: rtl/call_panel.sv
// Call panel: debounces the floor call buttons, latches request lights and
// holds the car at a served floor for a fixed door dwell.
module call_panel
  import call_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DWELL_CYCLES    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn1,
  input  logic btn2,
  input  logic btn3,
  input  logic floor1,
  input  logic floor2,
  input  logic floor3,
  input  logic door,
  input  logic moving,
  output logic led1,
  output logic led2,
  output logic led3,
  output logic hold
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_INIT = DW'(DWELL_CYCLES - 1);

  logic [NUM_FLOORS-1:0] btn;
  logic [NUM_FLOORS-1:0] at_floor;
  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] here;
  logic [NUM_FLOORS-1:0] led;
  logic [NUM_FLOORS-1:0] serve;

  assign btn      = {btn3, btn2, btn1};
  assign at_floor = {floor3, floor2, floor1};

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor
    floor_state_t  state;
    logic [DW-1:0] dwell;

    call_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn[i]),
      .press(press[i])
    );

    assign here[i] = at_floor[i] & door & ~moving;

    // led/serve are kept as flops alongside the state so the outputs never
    // see a path from the car inputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= IDLE;
        dwell    <= '0;
        led[i]   <= 1'b0;
        serve[i] <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (press[i] && here[i]) begin
              state    <= SERVE;
              dwell    <= DWELL_INIT;
              serve[i] <= 1'b1;
            end else if (press[i]) begin
              state  <= PENDING;
              led[i] <= 1'b1;
            end
          end
          PENDING: begin
            if (here[i]) begin
              state    <= SERVE;
              dwell    <= DWELL_INIT;
              led[i]   <= 1'b0;
              serve[i] <= 1'b1;
            end
          end
          SERVE: begin
            if (!here[i] || dwell == '0) begin
              state    <= IDLE;
              serve[i] <= 1'b0;
            end else begin
              dwell <= dwell - 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            dwell    <= '0;
            led[i]   <= 1'b0;
            serve[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign led1 = led[0];
  assign led2 = led[1];
  assign led3 = led[2];
  assign hold = |serve;

endmodule
